// File: rtl/hazard_sched_pkg.sv
// Shared encodings and constants for the pipeline hazard scheduler.
package hazard_sched_pkg;
   localparam int REG_W          = 4;
   localparam int DATA_W         = 16;
   localparam int MDU_CYCLES_DEF = 4;
   localparam int MDU_CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MDU_BUSY = 2'b01
   } sched_state_e;

   // Stage enables in one bundle; field order matches the output concatenation in the top.
   typedef struct packed {
      logic pc_write;
      logic pc_sel_branch;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_flush;
      logic exmem_write;
      logic exmem_flush;
   } ctl_t;

   localparam ctl_t CTL_DEF = '{pc_write:1'b1, pc_sel_branch:1'b0, ifid_write:1'b1, ifid_flush:1'b0,
                                idex_write:1'b1, idex_flush:1'b0, exmem_write:1'b1, exmem_flush:1'b0};
   localparam ctl_t CTL_RST = '{pc_write:1'b0, pc_sel_branch:1'b0, ifid_write:1'b0, ifid_flush:1'b1,
                                idex_write:1'b0, idex_flush:1'b1, exmem_write:1'b0, exmem_flush:1'b1};
   localparam ctl_t CTL_HOLD = '0;
   localparam ctl_t CTL_FRZ = '{pc_write:1'b0, pc_sel_branch:1'b0, ifid_write:1'b0, ifid_flush:1'b0,
                                idex_write:1'b0, idex_flush:1'b0, exmem_write:1'b0, exmem_flush:1'b1};
endpackage

// File: rtl/hazard_sched_if.sv
// Hazard inputs and stage-enable outputs between the pipeline and the scheduler.
interface hazard_sched_if #(parameter int STALL_CNT_W = 16);
   import hazard_sched_pkg::*;

   logic                   mem_busy;
   logic [REG_W-1:0]       ifid_rs;
   logic [REG_W-1:0]       ifid_rt;
   logic                   ifid_uses_rt;
   logic                   idex_mem_read;
   logic [REG_W-1:0]       idex_rt;
   logic                   idex_mdu_op;
   logic                   ex_branch_taken;
   logic                   pc_write;
   logic                   pc_sel_branch;
   logic                   ifid_write;
   logic                   ifid_flush;
   logic                   idex_write;
   logic                   idex_flush;
   logic                   exmem_write;
   logic                   exmem_flush;
   logic [1:0]             state;
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic [7:0]             flush_count;
   logic                   err;

   modport master (
      output mem_busy, ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt, idex_mdu_op,
             ex_branch_taken,
      input  pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, state, stall_cycles, flush_count, err
   );
   modport slave (
      input  mem_busy, ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_rt, idex_mdu_op,
             ex_branch_taken,
      output pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_flush, state, stall_cycles, flush_count, err
   );
endinterface

// File: rtl/hazard_sched_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 count <= '0;
      else if (inc && count != '1) count <= count + W'(1);
   end
endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller: per-cycle advance/hold/flush decisions from hazard inputs.
module hazard_sched
   import hazard_sched_pkg::*;
#(
   parameter int MDU_CYCLES  = MDU_CYCLES_DEF,
   parameter int STALL_CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   hazard_sched_if.slave bus
);
   sched_state_e         state_q, nxt_state;
   logic [MDU_CNT_W-1:0] mdu_cnt, nxt_cnt;
   logic                 err_q;
   logic                 load_use, stall_inc, flush_inc;
   ctl_t                 ctl;
   logic [STALL_CNT_W-1:0] stall_q;
   logic [7:0]           flush_q;

   assign load_use = bus.idex_mem_read &&
                     (bus.idex_rt == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));

   // Outputs are combinational so the pipeline sees the decision in the same cycle.
   always_comb begin
      ctl       = CTL_DEF;
      nxt_state = state_q;
      nxt_cnt   = mdu_cnt;
      flush_inc = 1'b0;
      if (!reset) begin
         ctl = CTL_RST;
      end else if (bus.mem_busy) begin
         ctl = CTL_HOLD;
      end else if (state_q == ST_RUN) begin
         if (bus.ex_branch_taken) begin
            ctl.pc_sel_branch = 1'b1;
            ctl.ifid_flush    = 1'b1;
            ctl.idex_flush    = 1'b1;
            flush_inc         = 1'b1;
         end else if (bus.idex_mdu_op) begin
            ctl       = CTL_FRZ;
            nxt_cnt   = MDU_CNT_W'(MDU_CYCLES - 2);
            nxt_state = ST_MDU_BUSY;
         end else if (load_use) begin
            ctl.pc_write   = 1'b0;
            ctl.ifid_write = 1'b0;
            ctl.idex_flush = 1'b1;
         end
      end else if (mdu_cnt != '0) begin
         ctl     = CTL_FRZ;
         nxt_cnt = mdu_cnt - MDU_CNT_W'(1);
      end else begin
         nxt_state = ST_RUN;
      end
   end

   assign stall_inc = reset && !ctl.pc_write;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         mdu_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= nxt_state;
         mdu_cnt <= nxt_cnt;
         if (bus.ex_branch_taken && bus.idex_mdu_op) err_q <= 1'b1;
      end
   end

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk(clk), .rst_n(reset), .inc(stall_inc), .count(stall_q)
   );
   sat_counter #(.W(8)) u_flush_cnt (
      .clk(clk), .rst_n(reset), .inc(flush_inc), .count(flush_q)
   );

   assign {bus.pc_write, bus.pc_sel_branch, bus.ifid_write, bus.ifid_flush,
           bus.idex_write, bus.idex_flush, bus.exmem_write, bus.exmem_flush} = ctl;
   assign bus.state        = state_q;
   assign bus.stall_cycles = stall_q;
   assign bus.flush_count  = flush_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_hazard_sched.sv
// Randomized + directed bench for hazard_sched against a cycle-level behavioural model.
module tb_hazard_sched;
   localparam int MDU_N = 4;
   localparam int SW    = 16;
   // {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush}
   localparam logic [7:0] E_DEF  = 8'b1010_1010;
   localparam logic [7:0] E_RST  = 8'b0001_0101;
   localparam logic [7:0] E_HOLD = 8'b0000_0000;
   localparam logic [7:0] E_FRZ  = 8'b0000_0001;
   localparam logic [7:0] E_BR   = 8'b1111_1110;
   localparam logic [7:0] E_LU   = 8'b0000_1110;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   hazard_sched_if #(.STALL_CNT_W(SW)) bus ();
   hazard_sched #(.MDU_CYCLES(MDU_N), .STALL_CNT_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drv(input logic mb, input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                      input logic mr, input logic [3:0] irt, input logic mdu, input logic br);
      bus.mem_busy = mb;  bus.ifid_rs = rs;       bus.ifid_rt = rt;   bus.ifid_uses_rt = urt;
      bus.idex_mem_read = mr; bus.idex_rt = irt; bus.idex_mdu_op = mdu; bus.ex_branch_taken = br;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: whether an MDU op owns EX, how many cycles it still owns EX, plus counters.
   bit          m_busy = 1'b0;
   int          m_left = 0;
   int          m_stall = 0;
   int          m_fc = 0;
   bit          m_err = 1'b0;
   logic [7:0]  e, act;
   bit          lu;

   always @(negedge clk) begin
      if (!reset) begin
         m_busy = 1'b0; m_left = 0; m_stall = 0; m_fc = 0; m_err = 1'b0;
      end
      chk("state", bus.state, {31'd0, m_busy});
      chk("stall_cycles", bus.stall_cycles, m_stall);
      chk("flush_count", bus.flush_count, m_fc);
      chk("err", bus.err, m_err);
      lu = bus.idex_mem_read && (bus.idex_rt == bus.ifid_rs ||
                                 (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));
      e = E_DEF;
      if (!reset) e = E_RST;
      else if (bus.mem_busy) e = E_HOLD;
      else if (!m_busy) begin
         if (bus.ex_branch_taken) begin
            e = E_BR; m_fc = (m_fc < 255) ? m_fc + 1 : 255;
         end else if (bus.idex_mdu_op) begin
            e = E_FRZ; m_busy = 1'b1; m_left = MDU_N - 1;
         end else if (lu) e = E_LU;
      end else if (m_left > 1) begin
         e = E_FRZ; m_left--;
      end else begin
         m_busy = 1'b0; m_left = 0;
      end
      act = {bus.pc_write, bus.pc_sel_branch, bus.ifid_write, bus.ifid_flush,
             bus.idex_write, bus.idex_flush, bus.exmem_write, bus.exmem_flush};
      chk("ctl", act, e);
      if (reset && !e[7]) m_stall = (m_stall < (1 << SW) - 1) ? m_stall + 1 : (1 << SW) - 1;
      if (reset && bus.ex_branch_taken && bus.idex_mdu_op) m_err = 1'b1;
   end

   int s0;
   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("rst_pc_write", bus.pc_write, 0);
      chk("rst_exmem_flush", bus.exmem_flush, 1);
      step();
      reset = 1'b1;
      #1 chk("idle_pc_write", bus.pc_write, 1);

      // load-use: exactly one bubble
      step(); drv(0, 5, 0, 0, 1, 5, 0, 0);
      #1 chk("lu_pc_write", bus.pc_write, 0);
      chk("lu_ifid_write", bus.ifid_write, 0);
      chk("lu_idex_flush", bus.idex_flush, 1);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("lu_stall", bus.stall_cycles, 1);
      chk("lu_release", bus.pc_write, 1);

      // branch wins over load-use
      step(); drv(0, 5, 0, 0, 1, 5, 0, 1);
      #1 chk("br_sel", bus.pc_sel_branch, 1);
      chk("br_pc_write", bus.pc_write, 1);
      chk("br_ifid_flush", bus.ifid_flush, 1);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("br_fc", bus.flush_count, 1);
      chk("br_stall", bus.stall_cycles, 1);

      // MDU held in EX for two back-to-back ops
      step(); drv(0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("mdu_entry_freeze", bus.exmem_flush, 1);
      step(); #1 chk("mdu_state1", bus.state, 1);
      step(); #1 chk("mdu_state2", bus.state, 1);
      step(); #1 chk("mdu_release", bus.pc_write, 1);
      chk("mdu_stall3", bus.stall_cycles, 4);
      step(); #1 chk("mdu2_entry", bus.pc_write, 0);
      step(); step(); step();
      #1 chk("mdu2_stall", bus.stall_cycles, 7);
      drv(0, 0, 0, 0, 0, 0, 0, 0);

      // mem_busy while one MDU freeze cycle remains
      step(); drv(0, 0, 0, 0, 0, 0, 1, 0);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      step(); s0 = bus.stall_cycles; drv(1, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("mb_writes", {bus.pc_write, bus.exmem_write, bus.exmem_flush}, 0);
      repeat (4) step();
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("mb_last_freeze", bus.exmem_flush, 1);
      step(); #1 chk("mb_release", bus.pc_write, 1);
      chk("mb_stall_delta", bus.stall_cycles - s0, 6);

      // branch + MDU together
      step(); drv(0, 0, 0, 0, 0, 0, 1, 1);
      #1 chk("err_br_sel", bus.pc_sel_branch, 1);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("err_set", bus.err, 1);
      chk("err_state", bus.state, 0);
      step(); #1 chk("err_sticky", bus.err, 1);

      // asynchronous reset in MDU_BUSY
      drv(0, 0, 0, 0, 0, 0, 1, 0);
      step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1 chk("arst_ctl", {bus.pc_write, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 4'b0111);
      chk("arst_state", bus.state, 0);
      chk("arst_err", bus.err, 0);
      step(); reset = 1'b1;
      #1 chk("arst_run", bus.pc_write, 1);
      chk("arst_stall", bus.stall_cycles, 0);

      // flush counter saturation
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      repeat (300) step();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      step(); #1 chk("fc_sat", bus.flush_count, 255);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         step();
         reset = ($urandom_range(0, 199) != 0);
         drv($urandom_range(0, 7) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
      step(); reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
